// File: rtl/eth_udp_pkt_gen_if.sv
// eth_udp_pkt_gen_if: payload byte stream in and Ethernet byte stream out of the UDP packet generator
interface eth_udp_pkt_gen_if;
  logic [7:0] S_Byte;
  logic       S_Valid;
  logic       S_Last;
  logic       S_Ready;
  logic [7:0] Eth_Byte;
  logic       Eth_Byte_Valid;
  modport master (output S_Byte, S_Valid, S_Last, input S_Ready, Eth_Byte, Eth_Byte_Valid);
  modport slave (input S_Byte, S_Valid, S_Last, output S_Ready, Eth_Byte, Eth_Byte_Valid);
endinterface

// File: rtl/eth_udp_pkt_gen.sv
// eth_udp_pkt_gen: buffers one payload, builds IPv4/UDP headers and streams header+payload+pad to the transmitter.
// Define ETH_UDP_CSUM_EN to compute the UDP checksum; otherwise the UDP checksum field is sent as zero.
module eth_udp_pkt_gen #(
  parameter int pMAX_PAYLOAD = 1472,
  parameter int pTTL = 64,
  parameter int pMIN_FRAME = 46
) (
  input  logic              Clk,
  input  logic              Rst,
  eth_udp_pkt_gen_if.slave  bus,
  input  logic [31:0]       Src_Ip_i,
  input  logic [31:0]       Dst_Ip_i,
  input  logic [15:0]       Src_Port_i,
  input  logic [15:0]       Dst_Port_i,
  input  logic              Tx_Idle_i,
  output logic              Eth_Pkt_Rdy_o,
  output logic              Drop_o
);
  localparam int AW = pMAX_PAYLOAD > 1 ? $clog2(pMAX_PAYLOAD) : 1;
  localparam logic [15:0] MAX_N = 16'(pMAX_PAYLOAD);
  localparam logic [15:0] MIN_F = 16'(pMIN_FRAME);
  localparam logic [2:0] ACCEPT  = 3'd0;
  localparam logic [2:0] DISCARD = 3'd1;
  localparam logic [2:0] CSUM    = 3'd2;
  localparam logic [2:0] WAIT_TX = 3'd3;
  localparam logic [2:0] HDR     = 3'd4;
  localparam logic [2:0] PAYLOAD = 3'd5;
  localparam logic [2:0] PAD     = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;
  logic [2:0]     st_q, st_d;
  logic [15:0]    cnt_q, cnt_d, n_q, id_q, tot_len, udp_len, ip_csum, udp_csum, ip_w;
  logic [31:0]    src_ip_q, dst_ip_q, acc_q;
  logic [15:0]    src_port_q, dst_port_q;
  logic [7:0]     buf_q [pMAX_PAYLOAD];
  logic [159:0]   ip_hdr0;
  logic [223:0]   hdr;
  logic           xfer, last_xfer, drop_q;
  logic [AW-1:0]  wr_idx, rd_idx;
  assign xfer      = bus.S_Valid & bus.S_Ready;
  assign last_xfer = xfer & bus.S_Last;
  assign tot_len   = n_q + 16'd28;
  assign udp_len   = n_q + 16'd8;
  assign ip_csum   = ~acc_q[15:0];
  assign ip_hdr0   = {16'h4500, tot_len, id_q, 16'h4000, 8'(pTTL), 8'h11, 16'h0000, src_ip_q, dst_ip_q};
  assign ip_w      = ip_hdr0[8'd159 - {cnt_q[3:0], 4'b0} -: 16];
  assign hdr       = {ip_hdr0[159:80], ip_csum, ip_hdr0[63:0], src_port_q, dst_port_q, udp_len, udp_csum};
  assign wr_idx    = AW'(cnt_q);
  assign rd_idx    = AW'(cnt_q - 16'd28);
`ifdef ETH_UDP_CSUM_EN
  logic [31:0]  ucs_q;
  logic [159:0] udp_hdr0;
  logic [15:0]  udp_w;
  // pseudo-header and UDP header also happen to be ten words, so they fold in alongside the IP words
  assign udp_hdr0 = {src_ip_q, dst_ip_q, 16'h0011, udp_len, src_port_q, dst_port_q, udp_len, 16'h0000};
  assign udp_w    = udp_hdr0[8'd159 - {cnt_q[3:0], 4'b0} -: 16];
  assign udp_csum = &ucs_q[15:0] ? 16'hFFFF : ~ucs_q[15:0];
  always_ff @(posedge Clk)
    if (Rst || st_q == DISCARD || st_q == DONE) ucs_q <= '0;
    else if (st_q == ACCEPT && xfer) ucs_q <= ucs_q + (cnt_q[0] ? {24'h0, bus.S_Byte} : {16'h0, bus.S_Byte, 8'h00});
    else if (st_q == CSUM) ucs_q <= cnt_q < 16'd10 ? ucs_q + {16'h0, udp_w} : {16'h0, ucs_q[15:0]} + {16'h0, ucs_q[31:16]};
`else
  assign udp_csum = 16'h0000;
`endif
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      ACCEPT: begin
        st_d  = last_xfer ? CSUM : (xfer && cnt_q + 16'd1 == MAX_N) ? DISCARD : ACCEPT;
        cnt_d = (last_xfer || (xfer && cnt_q + 16'd1 == MAX_N)) ? 16'd0 : xfer ? cnt_q + 16'd1 : cnt_q;
      end
      DISCARD: st_d = last_xfer ? ACCEPT : DISCARD;
      CSUM: begin
        st_d  = cnt_q == 16'd11 ? WAIT_TX : CSUM;
        cnt_d = cnt_q == 16'd11 ? 16'd0 : cnt_q + 16'd1;
      end
      WAIT_TX: st_d = Tx_Idle_i ? HDR : WAIT_TX;
      HDR: begin
        st_d  = cnt_q == 16'd27 ? PAYLOAD : HDR;
        cnt_d = cnt_q + 16'd1;
      end
      PAYLOAD: begin
        st_d  = cnt_q != tot_len - 16'd1 ? PAYLOAD : tot_len < MIN_F ? PAD : DONE;
        cnt_d = cnt_q + 16'd1;
      end
      PAD: begin
        st_d  = cnt_q == MIN_F - 16'd1 ? DONE : PAD;
        cnt_d = cnt_q + 16'd1;
      end
      default: begin
        st_d  = ACCEPT;
        cnt_d = 16'd0;
      end
    endcase
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      st_q   <= ACCEPT;
      cnt_q  <= '0;
      id_q   <= '0;
      acc_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      drop_q <= st_q == DISCARD && last_xfer;
      if (st_q == DONE) id_q <= id_q + 16'd1;
      // ten word additions, then two end-around-carry folds
      if (st_q == ACCEPT) acc_q <= '0;
      else if (st_q == CSUM) acc_q <= cnt_q < 16'd10 ? acc_q + {16'h0, ip_w} : {16'h0, acc_q[15:0]} + {16'h0, acc_q[31:16]};
    end
  always_ff @(posedge Clk) begin
    if (st_q == ACCEPT && xfer) buf_q[wr_idx] <= bus.S_Byte;
    if (st_q == ACCEPT && last_xfer) begin
      n_q        <= cnt_q + 16'd1;
      src_ip_q   <= Src_Ip_i;
      dst_ip_q   <= Dst_Ip_i;
      src_port_q <= Src_Port_i;
      dst_port_q <= Dst_Port_i;
    end
  end
  assign bus.S_Ready        = ~Rst & (st_q == ACCEPT || st_q == DISCARD);
  assign bus.Eth_Byte_Valid = st_q == HDR || st_q == PAYLOAD || st_q == PAD;
  assign bus.Eth_Byte       = st_q == HDR ? hdr[8'd223 - {cnt_q[4:0], 3'b0} -: 8] : st_q == PAYLOAD ? buf_q[rd_idx] : 8'h00;
  assign Eth_Pkt_Rdy_o      = st_q == DONE;
  assign Drop_o             = drop_q;
endmodule

// File: tb/tb_eth_udp_pkt_gen.sv
// tb_eth_udp_pkt_gen: scoreboard bench; a byte-level frame model feeds an expected queue drained by a monitor.
module tb_eth_udp_pkt_gen;
  localparam int MAXN = 24;
  typedef logic [7:0] bq_t[$];
  logic        Clk = 1'b0, Rst = 1'b1, Tx_Idle = 1'b1;
  logic [31:0] src_ip = '0, dst_ip = '0;
  logic [15:0] sport = '0, dport = '0;
  logic        Eth_Pkt_Rdy, Drop;
  int          exp_q[$];
  int          checks = 0, passes = 0, cyc = 0, hs_cyc = 0;
  logic [15:0] exp_id = '0;
  bit          lat_en = 1'b0, prev_valid = 1'b0;
  eth_udp_pkt_gen_if bus();
  eth_udp_pkt_gen #(.pMAX_PAYLOAD(MAXN)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus),
    .Src_Ip_i(src_ip), .Dst_Ip_i(dst_ip), .Src_Port_i(sport), .Dst_Port_i(dport),
    .Tx_Idle_i(Tx_Idle), .Eth_Pkt_Rdy_o(Eth_Pkt_Rdy), .Drop_o(Drop)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction
  function automatic void pop(input string name, input int act);
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL %s: unexpected output 0x%0h, nothing expected", name, act);
    end else check(name, act, exp_q.pop_front());
  endfunction
  function automatic logic [15:0] ones_sum(input bq_t b);
    int unsigned s = 0;
    for (int i = 0; i < b.size(); i += 2) s += {b[i], (i + 1 < b.size()) ? b[i+1] : 8'h00};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction
  task automatic expect_frame(input bq_t p);
    bq_t ip, udp;
    logic [15:0] tl, ul, ic;
    tl = 16'(28 + p.size());
    ul = 16'(8 + p.size());
    ip = {8'h45, 8'h00, tl[15:8], tl[7:0], exp_id[15:8], exp_id[7:0], 8'h40, 8'h00, 8'd64, 8'h11, 8'h00, 8'h00,
          src_ip[31:24], src_ip[23:16], src_ip[15:8], src_ip[7:0], dst_ip[31:24], dst_ip[23:16], dst_ip[15:8], dst_ip[7:0]};
    ic = ~ones_sum(ip);
    ip[10] = ic[15:8];
    ip[11] = ic[7:0];
    udp = {sport[15:8], sport[7:0], dport[15:8], dport[7:0], ul[15:8], ul[7:0], 8'h00, 8'h00};
`ifdef ETH_UDP_CSUM_EN
    begin
      bq_t ps;
      logic [15:0] uc;
      ps = {src_ip[31:24], src_ip[23:16], src_ip[15:8], src_ip[7:0], dst_ip[31:24], dst_ip[23:16], dst_ip[15:8], dst_ip[7:0],
            8'h00, 8'h11, ul[15:8], ul[7:0]};
      ps = {ps, udp, p};
      uc = ~ones_sum(ps);
      if (uc == 16'h0000) uc = 16'hFFFF;
      udp[6] = uc[15:8];
      udp[7] = uc[7:0];
    end
`endif
    foreach (ip[i]) exp_q.push_back(int'(ip[i]));
    foreach (udp[i]) exp_q.push_back(int'(udp[i]));
    foreach (p[i]) exp_q.push_back(int'(p[i]));
    for (int i = 28 + p.size(); i < 46; i++) exp_q.push_back(0);
    exp_q.push_back(256);
    exp_id++;
  endtask
  task automatic put_byte(input logic [7:0] b, input bit last);
    int g = 0;
    if ($urandom_range(0, 3) == 0) @(negedge Clk);
    @(negedge Clk);
    bus.S_Byte  = b;
    bus.S_Valid = 1'b1;
    bus.S_Last  = last;
    while (!bus.S_Ready && g < 4000) begin
      @(negedge Clk);
      g++;
    end
    if (g >= 4000) begin
      checks++;
      $display("FAIL s_ready_wait: S_Ready stayed 0 for %0d cycles, required 1", g);
    end
    hs_cyc = cyc + 1;
    @(posedge Clk);
    #1;
    bus.S_Valid = 1'b0;
    bus.S_Last  = 1'b0;
  endtask
  task automatic send(input bq_t p, input bit drop);
    foreach (p[i]) put_byte(p[i], i == p.size() - 1);
    if (drop) exp_q.push_back(257);
    else expect_frame(p);
  endtask
  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction
  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge Clk);
      g++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask
  always @(negedge Clk) begin
    if (Rst) prev_valid = 1'b0;
    else begin
      if (bus.Eth_Byte_Valid && !prev_valid && lat_en) check("first_byte_latency", cyc - hs_cyc, 13);
      if (prev_valid && !bus.Eth_Byte_Valid) check("pkt_rdy_after_last", int'(Eth_Pkt_Rdy), 1);
      if (bus.Eth_Byte_Valid) pop("eth_byte", int'(bus.Eth_Byte));
      if (Eth_Pkt_Rdy) pop("pkt_rdy", 256);
      if (Drop) pop("drop", 257);
      prev_valid = bus.Eth_Byte_Valid;
    end
  end
  initial begin
    bq_t p;
    int viol, g;
    bus.S_Byte = '0;
    bus.S_Valid = 1'b0;
    bus.S_Last = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_s_ready", int'(bus.S_Ready), 0);
    check("rst_eth_valid", int'(bus.Eth_Byte_Valid), 0);
    check("rst_eth_byte", int'(bus.Eth_Byte), 0);
    check("rst_pkt_rdy", int'(Eth_Pkt_Rdy), 0);
    check("rst_drop", int'(Drop), 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("accept_s_ready", int'(bus.S_Ready), 1);
    // reference packet from the plan, then an identical back-to-back one
    lat_en = 1'b1;
    src_ip = 32'hC0A8010A;
    dst_ip = 32'hC0A801FF;
    sport = 16'd5000;
    dport = 16'd5000;
    p = {};
    for (int i = 0; i < 18; i++) p.push_back(8'(i));
    send(p, 1'b0);
    send(p, 1'b0);
    send('{8'hAB}, 1'b0);
    send(rand_payload(17), 1'b0);
    send(rand_payload(MAXN + 4), 1'b1);
    send(rand_payload(MAXN), 1'b0);
    drain();
    Tx_Idle = 1'b0;
    lat_en = 1'b0;
    send(rand_payload(5), 1'b0);
    viol = 0;
    repeat (62) begin
      @(negedge Clk);
      if (bus.Eth_Byte_Valid || bus.S_Ready) viol++;
    end
    check("tx_idle_hold_quiet", viol, 0);
    Tx_Idle = 1'b1;
    @(negedge Clk);
    check("start_after_tx_idle", int'(bus.Eth_Byte_Valid), 1);
    @(posedge Clk);
    lat_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      src_ip = $urandom;
      dst_ip = $urandom;
      sport = 16'($urandom);
      dport = 16'($urandom);
      send(rand_payload($urandom_range(1, MAXN)), 1'b0);
    end
    drain();
    send(p, 1'b0);
    g = 0;
    while (!bus.Eth_Byte_Valid && g < 100) begin
      @(negedge Clk);
      g++;
    end
    check("frame_started_before_reset", int'(bus.Eth_Byte_Valid), 1);
    repeat (30) @(posedge Clk);
    #1 Rst = 1'b1;
    exp_q.delete();
    exp_id = '0;
    @(negedge Clk);
    @(negedge Clk);
    check("midrst_eth_valid", int'(bus.Eth_Byte_Valid), 0);
    check("midrst_eth_byte", int'(bus.Eth_Byte), 0);
    check("midrst_pkt_rdy", int'(Eth_Pkt_Rdy), 0);
    check("midrst_s_ready", int'(bus.S_Ready), 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    send(rand_payload(9), 1'b0);
    drain();
    repeat (5) @(negedge Clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/eth_udp_pkt_gen.md
Name: eth_udp_pkt_gen

Overview:
- Upstream feeder for the RMII transmit path. Accepts a user payload byte stream, buffers one packet, and computes IPv4 and UDP headers, including the IPv4 header checksum.
- Emits IPv4 header, UDP header, payload and zero padding as a byte stream on Eth_Byte/Eth_Byte_Valid, then pulses Eth_Pkt_Rdy so the transmitter frames the packet (preamble/MAC/FCS).
- One packet in flight at a time.

Parameters:
- pMAX_PAYLOAD, 1472, max UDP payload bytes; also the depth of the internal payload buffer.
- pTTL, 64, IPv4 TTL field value.
- pMIN_FRAME, 46, minimum Ethernet payload bytes; short packets are zero-padded up to this.

Ports:
- Clk  in  1  system clock (RMII reference domain)
- Rst  in  1  synchronous, active-high reset
- S_Byte  in  8  payload byte
- S_Valid  in  1  S_Byte valid
- S_Last  in  1  marks final payload byte; qualified by S_Valid
- S_Ready  out  1  block can accept a byte
- Src_Ip  in  32  IPv4 source; sampled on the S_Last handshake
- Dst_Ip  in  32  IPv4 destination; sampled on the S_Last handshake
- Src_Port  in  16  UDP source port; sampled on the S_Last handshake
- Dst_Port  in  16  UDP destination port; sampled on the S_Last handshake
- Tx_Idle  in  1  downstream transmitter idle (its FSM in IDLE)
- Eth_Byte  out  8  output byte to the transmitter FIFO
- Eth_Byte_Valid  out  1  Eth_Byte write strobe
- Eth_Pkt_Rdy  out  1  one-cycle pulse: packet fully written
- Drop  out  1  one-cycle pulse: oversized packet discarded

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous, active-high.
- Reset values: S_Ready=0 in the reset cycle, then 1 in ACCEPT. Eth_Byte=0, Eth_Byte_Valid=0, Eth_Pkt_Rdy=0, Drop=0. IP ID counter=0, byte count=0.
- Reset mid-operation: buffered payload is discarded, state returns to ACCEPT, and no partial Eth_Pkt_Rdy is issued.
- Handshake: a byte transfers when S_Valid and S_Ready are both 1. N = number of accepted bytes; N>=1.
- FSM states:
  - ACCEPT: S_Ready=1. Bytes are written to the buffer at index count. On S_Last, go to CSUM.
    - If count reaches pMAX_PAYLOAD without S_Last, go to DISCARD.
  - DISCARD: S_Ready=1, bytes are swallowed. On S_Last, pulse Drop for 1 cycle, go to ACCEPT. The ID counter is not incremented.
  - CSUM: S_Ready=0. Takes exactly 12 cycles: 10 cycles of 16-bit one's-complement accumulation over the header words with the checksum field = 0, then 2 end-around-carry fold cycles, then invert. Go to WAIT_TX.
  - WAIT_TX: hold until Tx_Idle=1, then go to HDR on the next cycle.
  - HDR: 28 bytes, one per cycle, Eth_Byte_Valid=1.
  - PAYLOAD: N bytes from the buffer, one per cycle, no gaps.
  - PAD: zero bytes until HDR+PAYLOAD+PAD = pMIN_FRAME. Skipped when 28+N >= pMIN_FRAME.
  - DONE: Eth_Pkt_Rdy=1 for one cycle, ID counter +1 (wraps at 0xFFFF->0), go to ACCEPT.
- Eth_Pkt_Rdy asserts the cycle after the last Eth_Byte_Valid.
- IPv4 header bytes, MSB first per field:
  - 0x45, 0x00
  - total length 28+N
  - ID counter
  - 0x4000 (DF set)
  - pTTL, 0x11
  - checksum
  - Src_Ip, Dst_Ip
- UDP header: Src_Port, Dst_Port, length 8+N, checksum field.
- Arithmetic: lengths are 16-bit. The checksum accumulator is 17 bits or wider and folded twice.
- Latency: first header byte appears 13 cycles after the S_Last handshake when Tx_Idle is already 1.

Optional Feature:
- Macro: ETH_UDP_CSUM_EN.
- Defined: UDP checksum is computed as the one's-complement sum of the pseudo-header (src IP, dst IP, 0x0011, UDP length), the UDP header, and the payload, with an odd payload padded by a 0x00 low byte.
  - Payload words are accumulated during ACCEPT; the rest is added during CSUM, so CSUM latency is unchanged.
  - A computed result of 0x0000 is sent as 0xFFFF.
- Undefined: UDP checksum field = 0x0000, and the payload accumulator is not built.

Test Plan:
- N=18 bytes 0x00..0x11, Src_Ip=C0A8010A, Dst_Ip=C0A801FF, ports 5000/5000, Tx_Idle=1:
  - 46 Eth_Byte_Valid cycles; total length=0x002E, ID=0x0000, IP checksum=0xB665, UDP length=0x001A, no pad.
  - Eth_Pkt_Rdy pulses once, the cycle after byte 46.
- N=1 byte 0xAB: 29 data bytes then 17 bytes of 0x00; total length=0x001D, UDP length=0x0009.
- Two back-to-back packets: second packet's ID field=0x0001, and its checksum is recomputed to match.
- pMAX_PAYLOAD=16, send 20 bytes with S_Last on byte 20: Drop pulses once, no Eth_Byte_Valid, next packet's ID=0x0000.
- Tx_Idle held 0 for 50 cycles after CSUM: no Eth_Byte_Valid and S_Ready=0 throughout; output starts 1 cycle after Tx_Idle rises.
- Rst asserted mid-PAYLOAD: all outputs go to reset values the next cycle, no Eth_Pkt_Rdy; the following packet is correct with ID=0x0000.
